// File: rtl/axi_wr_rsp_gen.sv
// AXI slave write-response generator: pairs queued AW IDs with WLAST status in arrival order and drives the B channel.
// Optional AXI_WR_RSP_STATS_EN adds saturating response/error counters (rsp_cnt, err_cnt).
module axi_wr_rsp_gen #(
  parameter int DEPTH  = 4,
  parameter int ID_W   = 1,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aw_fire,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [USER_W-1:0] aw_user,
  output logic              aw_full,
  input  logic              w_last_fire,
  input  logic              w_err,
  output logic              w_full,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic              bresp,
  output logic [USER_W-1:0] buser
`ifdef AXI_WR_RSP_STATS_EN
  ,
  output logic [15:0]       rsp_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = ID_W + USER_W;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  // B handshake: a response transfers on a clock edge where bvalid && bready;
  // once bvalid rises, bid/bresp/buser stay frozen until that transfer.
  typedef enum logic {IDLE, VALID} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] idq_mem [DEPTH];
  logic [PW-1:0] idq_wr, idq_rd;
  logic [CW-1:0] idq_cnt;
  logic          stq_mem [DEPTH];
  logic [PW-1:0] stq_wr, stq_rd;
  logic [CW-1:0] stq_cnt;

  logic          id_push, st_push, pop, both_avail;
  logic [IW-1:0] id_head;

  // Full flags decode registered counts, so a pop in the same cycle never frees a slot early.
  assign aw_full    = (idq_cnt == FULL_C);
  assign w_full     = (stq_cnt == FULL_C);
  assign id_push    = aw_fire && !aw_full;
  assign st_push    = w_last_fire && !w_full;
  assign both_avail = (idq_cnt != '0) && (stq_cnt != '0);
  assign id_head    = idq_mem[idq_rd];
  assign bvalid     = (state == VALID);

  always_ff @(posedge clk) begin
    if (id_push) idq_mem[idq_wr] <= {aw_id, aw_user};
    if (st_push) stq_mem[stq_wr] <= w_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idq_wr  <= '0;
      idq_rd  <= '0;
      idq_cnt <= '0;
      stq_wr  <= '0;
      stq_rd  <= '0;
      stq_cnt <= '0;
    end else begin
      if (id_push) idq_wr <= idq_wr + PW'(1);
      if (st_push) stq_wr <= stq_wr + PW'(1);
      if (pop) begin
        idq_rd <= idq_rd + PW'(1);
        stq_rd <= stq_rd + PW'(1);
      end
      case ({id_push, pop})
        2'b10:   idq_cnt <= idq_cnt + CW'(1);
        2'b01:   idq_cnt <= idq_cnt - CW'(1);
        default: idq_cnt <= idq_cnt;
      endcase
      case ({st_push, pop})
        2'b10:   stq_cnt <= stq_cnt + CW'(1);
        2'b01:   stq_cnt <= stq_cnt - CW'(1);
        default: stq_cnt <= stq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // bready only steers the pop/next-state decision; every B output comes from a register.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (both_avail) begin
          pop       = 1'b1;
          state_nxt = VALID;
        end
      end
      VALID: begin
        if (bready) begin
          if (both_avail) pop = 1'b1;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bid   <= '0;
      buser <= '0;
      bresp <= 1'b0;
    end else if (pop) begin
      bid   <= id_head[IW-1:USER_W];
      buser <= id_head[USER_W-1:0];
      bresp <= stq_mem[stq_rd];
    end
  end

`ifdef AXI_WR_RSP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_cnt <= '0;
      err_cnt <= '0;
    end else if (bvalid && bready) begin
      if (rsp_cnt != 16'hFFFF) rsp_cnt <= rsp_cnt + 16'd1;
      if (bresp && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_rsp_gen.sv
// Self-checking bench for axi_wr_rsp_gen: queue-level reference model compared every cycle plus directed literal checks.
module tb_axi_wr_rsp_gen;
  localparam int DEPTH  = 4;
  localparam int ID_W   = 1;
  localparam int USER_W = 1;
  localparam int IW     = ID_W + USER_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aw_fire = 1'b0;
  logic [ID_W-1:0]   aw_id = '0;
  logic [USER_W-1:0] aw_user = '0;
  logic              aw_full;
  logic              w_last_fire = 1'b0;
  logic              w_err = 1'b0;
  logic              w_full;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ID_W-1:0]   bid;
  logic              bresp;
  logic [USER_W-1:0] buser;
`ifdef AXI_WR_RSP_STATS_EN
  logic [15:0]       rsp_cnt, err_cnt;
`endif

  axi_wr_rsp_gen #(.DEPTH(DEPTH), .ID_W(ID_W), .USER_W(USER_W)) dut (
    .clk(clk), .rst(rst),
    .aw_fire(aw_fire), .aw_id(aw_id), .aw_user(aw_user), .aw_full(aw_full),
    .w_last_fire(w_last_fire), .w_err(w_err), .w_full(w_full),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser)
`ifdef AXI_WR_RSP_STATS_EN
    , .rsp_cnt(rsp_cnt), .err_cnt(err_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  int n_chk  = 0;
  int n_pass = 0;
  int rsp_seen = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
  endtask

  // reference model: pending AWs and WLAST statuses as plain queues
  logic [IW-1:0] exp_q[$];
  logic          sts_q[$];
  logic              m_bvalid = 1'b0;
  logic [ID_W-1:0]   m_bid = '0;
  logic              m_bresp = 1'b0;
  logic [USER_W-1:0] m_buser = '0;
  logic              m_aw_full = 1'b0, m_w_full = 1'b0;
  int                m_rsp = 0, m_err = 0;

  always @(posedge clk) begin
    logic hs, take, a_ok, w_ok;
    logic [IW-1:0] e;
    if (rst) begin
      exp_q.delete();
      sts_q.delete();
      m_bvalid = 1'b0; m_bid = '0; m_bresp = 1'b0; m_buser = '0;
      m_rsp = 0; m_err = 0;
    end else begin
      hs   = m_bvalid && bready;
      if (hs) begin
        if (m_rsp < 65535) m_rsp++;
        if (m_bresp && m_err < 65535) m_err++;
      end
      take = (!m_bvalid || bready) && exp_q.size() > 0 && sts_q.size() > 0;
      a_ok = aw_fire && exp_q.size() < DEPTH;
      w_ok = w_last_fire && sts_q.size() < DEPTH;
      if (take) begin
        e = exp_q.pop_front();
        m_bid = e[IW-1:USER_W];
        m_buser = e[USER_W-1:0];
        m_bresp = sts_q.pop_front();
        m_bvalid = 1'b1;
      end else if (hs) begin
        m_bvalid = 1'b0;
      end
      if (a_ok) exp_q.push_back({aw_id, aw_user});
      if (w_ok) sts_q.push_back(w_err);
    end
    m_aw_full = (exp_q.size() == DEPTH);
    m_w_full  = (sts_q.size() == DEPTH);
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("bvalid", 32'(bvalid), 32'(m_bvalid));
      chk("aw_full", 32'(aw_full), 32'(m_aw_full));
      chk("w_full", 32'(w_full), 32'(m_w_full));
      if (m_bvalid) begin
        chk("bid", 32'(bid), 32'(m_bid));
        chk("bresp", 32'(bresp), 32'(m_bresp));
        chk("buser", 32'(buser), 32'(m_buser));
      end
`ifdef AXI_WR_RSP_STATS_EN
      chk("rsp_cnt", 32'(rsp_cnt), 32'(m_rsp));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
      if (bvalid && bready && !rst) rsp_seen++;
    end
  end

  // driver tasks: each step holds the given inputs for one clock cycle
  task automatic step(input logic a, input logic [ID_W-1:0] id, input logic [USER_W-1:0] u,
                      input logic wl, input logic e, input logic br);
    aw_fire = a; aw_id = id; aw_user = u;
    w_last_fire = wl; w_err = e; bready = br;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic br);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, br);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    idle(1, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    idle(3, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // reset state
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_buser", 32'(buser), 32'd0);
    chk("rst_aw_full", 32'(aw_full), 32'd0);
    chk("rst_w_full", 32'(w_full), 32'd0);

    // single burst: AW and WLAST together in cycle N, bvalid in N+2
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_n1_bvalid", 32'(bvalid), 32'd0);
    idle(1, 1'b0);
    chk("t1_n2_bvalid", 32'(bvalid), 32'd1);
    chk("t1_bid", 32'(bid), 32'd1);
    chk("t1_bresp", 32'(bresp), 32'd0);
    idle(1, 1'b1);
    chk("t1_after_bvalid", 32'(bvalid), 32'd0);

    // W before AW: WLAST err at cycle 0, AW id 0 at cycle 5, bvalid at cycle 7
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_c6_bvalid", 32'(bvalid), 32'd0);
    idle(1, 1'b0);
    chk("t2_c7_bvalid", 32'(bvalid), 32'd1);
    chk("t2_bid", 32'(bid), 32'd0);
    chk("t2_bresp", 32'(bresp), 32'd1);
    chk("t2_buser", 32'(buser), 32'd1);
    idle(1, 1'b1);
    chk("t2_after_bvalid", 32'(bvalid), 32'd0);

    // backpressure: ids 0,1,0 queued, held 10 cycles, then drained back-to-back
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_bvalid", 32'(bvalid), 32'd1);
      chk("t3_hold_bid", 32'(bid), 32'd0);
      idle(1, 1'b0);
    end
    idle(1, 1'b1);
    chk("t3_r2_bid", 32'(bid), 32'd1);
    chk("t3_r2_bresp", 32'(bresp), 32'd1);
    idle(1, 1'b1);
    chk("t3_r3_bvalid", 32'(bvalid), 32'd1);
    chk("t3_r3_bid", 32'(bid), 32'd0);
    idle(1, 1'b1);
    chk("t3_end_bvalid", 32'(bvalid), 32'd0);

    // full ID queue: 4 AWs fill it, 5th ignored, 4 WLASTs give exactly 4 responses
    for (int i = 0; i < 4; i++) step(1'b1, ID_W'(i % 2), '0, 1'b0, 1'b0, 1'b1);
    chk("t4_aw_full", 32'(aw_full), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_aw_full_hold", 32'(aw_full), 32'd1);
    r0 = rsp_seen;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    chk("t4_rsp_count", 32'(rsp_seen - r0), 32'd4);
    chk("t4_aw_full_clr", 32'(aw_full), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    chk("t4_no_fifth", 32'(rsp_seen - r0), 32'd4);
    pulse_rst();

    // full status queue
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("t4b_w_full", 32'(w_full), 32'd1);
    pulse_rst();
    chk("t4b_w_full_rst", 32'(w_full), 32'd0);

    // reset mid-operation with a response pending and 2 pairs queued
    for (int i = 0; i < 3; i++) step(1'b1, ID_W'(i), '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("t5_pre_bvalid", 32'(bvalid), 32'd1);
    pulse_rst();
    chk("t5_bvalid", 32'(bvalid), 32'd0);
    chk("t5_aw_full", 32'(aw_full), 32'd0);
    chk("t5_w_full", 32'(w_full), 32'd0);
    r0 = rsp_seen;
    idle(6, 1'b1);
    chk("t5_no_rsp", 32'(rsp_seen - r0), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 99) < 40), ID_W'($urandom), USER_W'($urandom),
           1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 70));
    idle(20, 1'b1);

`ifdef AXI_WR_RSP_STATS_EN
    // 5 responses, 2 with error
    pulse_rst();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(8, 1'b1);
    chk("stats_rsp_cnt", 32'(rsp_cnt), 32'd5);
    chk("stats_err_cnt", 32'(err_cnt), 32'd2);
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
